// File: rtl/quad_encoder_counter_pkg.sv
// Shared definitions for quadrature decoding: transition codes and the
// legal Gray-code position sequence (forward rotation order S0->S1->S2->S3).
package quad_encoder_counter_pkg;

    localparam logic [1:0] TR_NONE    = 2'd0;
    localparam logic [1:0] TR_UP      = 2'd1;
    localparam logic [1:0] TR_DOWN    = 2'd2;
    localparam logic [1:0] TR_ILLEGAL = 2'd3;

    localparam logic [1:0] AB_S0 = 2'b00;
    localparam logic [1:0] AB_S1 = 2'b01;
    localparam logic [1:0] AB_S2 = 2'b11;
    localparam logic [1:0] AB_S3 = 2'b10;

endpackage

// File: rtl/quad_step_decode.sv
// Combinational classifier of one {A,B} sample pair into none/up/down/illegal.
// Kept standalone so other encoder or jog blocks can reuse it.
module quad_step_decode
    import quad_encoder_counter_pkg::*;
(
    input  logic [1:0] prev_ab,
    input  logic [1:0] cur_ab,
    output logic [1:0] tr
);

    // Full 16-entry lookup of the previous/current phase pair
    always_comb begin
        tr = TR_NONE;
        case ({prev_ab, cur_ab})
            {AB_S0, AB_S0}: tr = TR_NONE;
            {AB_S0, AB_S1}: tr = TR_UP;
            {AB_S0, AB_S2}: tr = TR_ILLEGAL;
            {AB_S0, AB_S3}: tr = TR_DOWN;
            {AB_S1, AB_S0}: tr = TR_DOWN;
            {AB_S1, AB_S1}: tr = TR_NONE;
            {AB_S1, AB_S2}: tr = TR_UP;
            {AB_S1, AB_S3}: tr = TR_ILLEGAL;
            {AB_S2, AB_S0}: tr = TR_ILLEGAL;
            {AB_S2, AB_S1}: tr = TR_DOWN;
            {AB_S2, AB_S2}: tr = TR_NONE;
            {AB_S2, AB_S3}: tr = TR_UP;
            {AB_S3, AB_S0}: tr = TR_UP;
            {AB_S3, AB_S1}: tr = TR_ILLEGAL;
            {AB_S3, AB_S2}: tr = TR_DOWN;
            {AB_S3, AB_S3}: tr = TR_NONE;
            default:        tr = TR_NONE;
        endcase
    end

endmodule

// File: rtl/quad_encoder_counter.sv
// Quadrature encoder counter: decodes Gray-code quarter-steps, groups them
// into detent steps and accumulates a wrapping or saturating value for PWM.
module quad_encoder_counter
    import quad_encoder_counter_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int STEP            = 1,
    parameter int PULSES_PER_STEP = 4,
    parameter int SATURATE        = 0,
    parameter int RESET_VALUE     = 0
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enc_a,
    input  logic             enc_b,
    output logic [WIDTH-1:0] value,
    output logic             step_pulse,
    output logic             dir,
    output logic             err
);

    localparam int ACC_W = $clog2(PULSES_PER_STEP) + 1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(PULSES_PER_STEP - 1);
    localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;
    localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);
    localparam logic [WIDTH:0]   STEP_X  = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] MAX_V   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RESET_VALUE);
    localparam bit               SAT_EN  = (SATURATE != 0);

    logic [1:0]              cur_ab_s;
    logic [1:0]              prev_ab_r;
    logic [1:0]              tr_s;
    logic [1:0]              tr_r;
    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] acc_nxt_s;
    logic [WIDTH-1:0]        value_r;
    logic [WIDTH-1:0]        value_nxt_s;
    logic [WIDTH:0]          sum_s;
    logic [WIDTH:0]          diff_s;
    logic [WIDTH-1:0]        up_val_s;
    logic [WIDTH-1:0]        dn_val_s;
    logic                    dir_r;
    logic                    dir_nxt_s;
    logic                    step_pulse_r;
    logic                    err_r;

    assign cur_ab_s = {enc_a, enc_b};

    quad_step_decode u_decode (
        .prev_ab (prev_ab_r),
        .cur_ab  (cur_ab_s),
        .tr      (tr_s)
    );

    // Candidate up/down values; the extra MSB is the carry or borrow
    always_comb begin
        sum_s    = {1'b0, value_r} + STEP_X;
        diff_s   = {1'b0, value_r} - STEP_X;
        up_val_s = (SAT_EN && sum_s[WIDTH])  ? MAX_V        : sum_s[WIDTH-1:0];
        dn_val_s = (SAT_EN && diff_s[WIDTH]) ? {WIDTH{1'b0}} : diff_s[WIDTH-1:0];
    end

    // Quarter-step accumulation and detent step issue from the registered transition
    always_comb begin
        acc_nxt_s   = acc_r;
        value_nxt_s = value_r;
        dir_nxt_s   = dir_r;
        case (tr_r)
            TR_UP: begin
                if (acc_r == ACC_MAX) begin
                    acc_nxt_s   = {ACC_W{1'b0}};
                    value_nxt_s = up_val_s;
                    dir_nxt_s   = 1'b1;
                end else begin
                    acc_nxt_s   = acc_r + ACC_ONE;
                end
            end
            TR_DOWN: begin
                if (acc_r == ACC_MIN) begin
                    acc_nxt_s   = {ACC_W{1'b0}};
                    value_nxt_s = dn_val_s;
                    dir_nxt_s   = 1'b0;
                end else begin
                    acc_nxt_s   = acc_r - ACC_ONE;
                end
            end
            default: begin
                acc_nxt_s   = acc_r;
                value_nxt_s = value_r;
                dir_nxt_s   = dir_r;
            end
        endcase
    end

    // State and output registers; reset captures the live phases so release never counts
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_ab_r    <= cur_ab_s;
            tr_r         <= TR_NONE;
            acc_r        <= {ACC_W{1'b0}};
            value_r      <= RST_V;
            dir_r        <= 1'b0;
            step_pulse_r <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            prev_ab_r    <= cur_ab_s;
            tr_r         <= tr_s;
            acc_r        <= acc_nxt_s;
            value_r      <= value_nxt_s;
            dir_r        <= dir_nxt_s;
            step_pulse_r <= (value_nxt_s != value_r);
            err_r        <= (tr_r == TR_ILLEGAL);
        end
    end

    assign value      = value_r;
    assign step_pulse = step_pulse_r;
    assign dir        = dir_r;
    assign err        = err_r;

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Bench for quad_encoder_counter: five parameterisations share one encoder
// stimulus and are checked against a position-difference reference model.
module tb_quad_encoder_counter;

    localparam int N = 5;

    logic       clk;
    logic       reset_n;
    logic       enc_a;
    logic       enc_b;
    logic [7:0] val [N];
    logic       sp  [N];
    logic       dr  [N];
    logic       er  [N];

    int p_step [N] = '{1, 1, 1, 5, 7};
    int p_pps  [N] = '{4, 4, 4, 1, 2};
    int p_sat  [N] = '{0, 0, 1, 1, 1};
    int p_rv   [N] = '{0, 255, 255, 3, 250};

    int m_acc [N];
    int m_val [N];
    bit m_sp  [N];
    bit m_dir [N];
    bit m_err [N];
    int prev_pos;
    int pend;
    int n_cmp;
    int n_fail;
    logic [1:0] ab_of [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    quad_encoder_counter #(.WIDTH(8), .STEP(1), .PULSES_PER_STEP(4), .SATURATE(0), .RESET_VALUE(0)) u0 (
        .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b),
        .value(val[0]), .step_pulse(sp[0]), .dir(dr[0]), .err(er[0]));
    quad_encoder_counter #(.WIDTH(8), .STEP(1), .PULSES_PER_STEP(4), .SATURATE(0), .RESET_VALUE(255)) u1 (
        .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b),
        .value(val[1]), .step_pulse(sp[1]), .dir(dr[1]), .err(er[1]));
    quad_encoder_counter #(.WIDTH(8), .STEP(1), .PULSES_PER_STEP(4), .SATURATE(1), .RESET_VALUE(255)) u2 (
        .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b),
        .value(val[2]), .step_pulse(sp[2]), .dir(dr[2]), .err(er[2]));
    quad_encoder_counter #(.WIDTH(8), .STEP(5), .PULSES_PER_STEP(1), .SATURATE(1), .RESET_VALUE(3)) u3 (
        .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b),
        .value(val[3]), .step_pulse(sp[3]), .dir(dr[3]), .err(er[3]));
    quad_encoder_counter #(.WIDTH(8), .STEP(7), .PULSES_PER_STEP(2), .SATURATE(1), .RESET_VALUE(250)) u4 (
        .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b),
        .value(val[4]), .step_pulse(sp[4]), .dir(dr[4]), .err(er[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pos_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // Model: position difference mod 4 gives 0 none, 1 up, 2 illegal, 3 down;
    // the effect of a transition appears one edge after it is sampled.
    task automatic model_update(input logic [1:0] ab, input logic rn);
        int cp;
        int nv;
        cp = pos_of(ab);
        if (!rn) begin
            for (int i = 0; i < N; i++) begin
                m_val[i] = p_rv[i]; m_acc[i] = 0;
                m_sp[i] = 1'b0; m_dir[i] = 1'b0; m_err[i] = 1'b0;
            end
            pend = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                m_sp[i]  = 1'b0;
                m_err[i] = (pend == 2);
                if (pend == 1) begin
                    if (m_acc[i] == p_pps[i] - 1) begin
                        m_acc[i] = 0; m_dir[i] = 1'b1;
                        nv = m_val[i] + p_step[i];
                        if (nv > 255) nv = (p_sat[i] != 0) ? 255 : nv - 256;
                        m_sp[i] = (nv != m_val[i]); m_val[i] = nv;
                    end else m_acc[i]++;
                end else if (pend == 3) begin
                    if (m_acc[i] == -(p_pps[i] - 1)) begin
                        m_acc[i] = 0; m_dir[i] = 1'b0;
                        nv = m_val[i] - p_step[i];
                        if (nv < 0) nv = (p_sat[i] != 0) ? 0 : nv + 256;
                        m_sp[i] = (nv != m_val[i]); m_val[i] = nv;
                    end else m_acc[i]--;
                end
            end
            pend = (cp - prev_pos + 4) % 4;
        end
        prev_pos = cp;
    endtask

    task automatic tick(input logic [1:0] ab, input logic rn);
        @(negedge clk);
        {enc_a, enc_b} = ab;
        reset_n = rn;
        @(posedge clk);
        #1;
        model_update(ab, rn);
    endtask

    task automatic test_reset();
        tick(2'b11, 1'b0);
        tick(2'b11, 1'b0);
        for (int c = 0; c < 10; c++) begin
            tick(2'b11, 1'b1);
            for (int i = 0; i < N; i++) begin
                n_cmp++;
                if (val[i] !== 8'(m_val[i]) || sp[i] !== m_sp[i] || dr[i] !== m_dir[i] || er[i] !== m_err[i]) begin
                    n_fail++;
                    $display("FAIL reset inst%0d: got val=%0d sp=%0b dir=%0b err=%0b, want val=%0d sp=%0b dir=%0b err=%0b",
                             i, val[i], sp[i], dr[i], er[i], m_val[i], m_sp[i], m_dir[i], m_err[i]);
                end
            end
            n_cmp++;
            if (val[0] !== 8'd0 || sp[0] !== 1'b0 || er[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle: got val=%0d sp=%0b err=%0b, want 0/0/0", val[0], sp[0], er[0]);
            end
        end
    endtask

    task automatic test_detent();
        logic [1:0] seq [4];
        int pulses [3];
        int pulse_at;
        int t;
        seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        pulses = '{0, 0, 0};
        pulse_at = -1;
        t = 0;
        tick(2'b00, 1'b0);
        tick(2'b00, 1'b0);
        for (int s = 0; s < 5; s++) begin
            for (int r = 0; r < 3; r++) begin
                tick((s < 4) ? seq[s] : 2'b00, 1'b1);
                for (int i = 0; i < N; i++) begin
                    n_cmp++;
                    if (val[i] !== 8'(m_val[i]) || sp[i] !== m_sp[i] || dr[i] !== m_dir[i] || er[i] !== m_err[i]) begin
                        n_fail++;
                        $display("FAIL detent inst%0d: got val=%0d sp=%0b dir=%0b err=%0b, want val=%0d sp=%0b dir=%0b err=%0b",
                                 i, val[i], sp[i], dr[i], er[i], m_val[i], m_sp[i], m_dir[i], m_err[i]);
                    end
                end
                for (int i = 0; i < 3; i++) if (sp[i] === 1'b1) pulses[i]++;
                if (sp[0] === 1'b1) pulse_at = t;
                t++;
            end
        end
        n_cmp++;
        if (pulses[0] !== 1 || pulse_at !== 10 || val[0] !== 8'd1 || dr[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL detent_up: got pulses=%0d at=%0d val=%0d dir=%0b, want 1 at 10, val=1 dir=1",
                     pulses[0], pulse_at, val[0], dr[0]);
        end
        n_cmp++;
        if (pulses[1] !== 1 || val[1] !== 8'd0) begin
            n_fail++;
            $display("FAIL detent_wrap: got pulses=%0d val=%0d, want 1 and 0", pulses[1], val[1]);
        end
        n_cmp++;
        if (pulses[2] !== 0 || val[2] !== 8'd255 || dr[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL detent_sat: got pulses=%0d val=%0d dir=%0b, want 0, 255, 1", pulses[2], val[2], dr[2]);
        end
    endtask

    task automatic test_reversal();
        logic [1:0] seq [8];
        int pulses;
        seq = '{2'b01, 2'b11, 2'b10, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00};
        pulses = 0;
        tick(2'b00, 1'b0);
        for (int s = 0; s < 8; s++) begin
            for (int r = 0; r < 2; r++) begin
                tick(seq[s], 1'b1);
                if (sp[0] === 1'b1) pulses++;
                for (int i = 0; i < N; i++) begin
                    n_cmp++;
                    if (val[i] !== 8'(m_val[i]) || sp[i] !== m_sp[i] || dr[i] !== m_dir[i] || er[i] !== m_err[i]) begin
                        n_fail++;
                        $display("FAIL reversal inst%0d: got val=%0d sp=%0b dir=%0b err=%0b, want val=%0d sp=%0b dir=%0b err=%0b",
                                 i, val[i], sp[i], dr[i], er[i], m_val[i], m_sp[i], m_dir[i], m_err[i]);
                    end
                end
            end
        end
        n_cmp++;
        if (pulses !== 0 || val[0] !== 8'd0) begin
            n_fail++;
            $display("FAIL reversal_hold: got pulses=%0d val=%0d, want 0 and 0", pulses, val[0]);
        end
    endtask

    task automatic test_illegal();
        logic [1:0] seq [6];
        int errs;
        seq = '{2'b11, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11};
        errs = 0;
        tick(2'b00, 1'b0);
        for (int s = 0; s < 6; s++) begin
            for (int r = 0; r < 2; r++) begin
                tick(seq[s], 1'b1);
                if (er[0] === 1'b1) errs++;
                for (int i = 0; i < N; i++) begin
                    n_cmp++;
                    if (val[i] !== 8'(m_val[i]) || sp[i] !== m_sp[i] || dr[i] !== m_dir[i] || er[i] !== m_err[i]) begin
                        n_fail++;
                        $display("FAIL illegal inst%0d: got val=%0d sp=%0b dir=%0b err=%0b, want val=%0d sp=%0b dir=%0b err=%0b",
                                 i, val[i], sp[i], dr[i], er[i], m_val[i], m_sp[i], m_dir[i], m_err[i]);
                    end
                end
            end
        end
        tick(2'b11, 1'b1);
        n_cmp++;
        if (errs !== 1 || val[0] !== 8'd1) begin
            n_fail++;
            $display("FAIL illegal_jump: got err_cycles=%0d val=%0d, want 1 and 1", errs, val[0]);
        end
    endtask

    task automatic test_sat_down();
        tick(2'b00, 1'b0);
        tick(2'b10, 1'b1);
        tick(2'b10, 1'b1);
        n_cmp++;
        if (val[3] !== 8'd0 || sp[3] !== 1'b1 || dr[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_down_first: got val=%0d sp=%0b dir=%0b, want 0/1/0", val[3], sp[3], dr[3]);
        end
        tick(2'b11, 1'b1);
        tick(2'b11, 1'b1);
        n_cmp++;
        if (val[3] !== 8'd0 || sp[3] !== 1'b0 || dr[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_down_again: got val=%0d sp=%0b dir=%0b, want 0/0/0", val[3], sp[3], dr[3]);
        end
    endtask

    task automatic test_random();
        int p;
        int r;
        logic rn;
        p = $urandom_range(0, 3);
        tick(ab_of[p], 1'b0);
        for (int c = 0; c < 800; c++) begin
            r  = $urandom_range(0, 99);
            rn = 1'b1;
            if (r < 3)       rn = 1'b0;
            else if (r < 8)  p = (p + 2) % 4;
            else if (r < 35) p = p;
            else if (r < 70) p = (p + 1) % 4;
            else             p = (p + 3) % 4;
            tick(ab_of[p], rn);
            for (int i = 0; i < N; i++) begin
                n_cmp++;
                if (val[i] !== 8'(m_val[i]) || sp[i] !== m_sp[i] || dr[i] !== m_dir[i] || er[i] !== m_err[i]) begin
                    n_fail++;
                    $display("FAIL random c%0d inst%0d: got val=%0d sp=%0b dir=%0b err=%0b, want val=%0d sp=%0b dir=%0b err=%0b",
                             c, i, val[i], sp[i], dr[i], er[i], m_val[i], m_sp[i], m_dir[i], m_err[i]);
                end
            end
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        prev_pos = 0;
        pend     = 0;
        reset_n  = 1'b0;
        enc_a    = 1'b0;
        enc_b    = 1'b0;
        test_reset();
        test_detent();
        test_reversal();
        test_illegal();
        test_sat_down();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/quad_encoder_counter.md
Name: quad_encoder_counter

Overview:
Consumes the two debounced quadrature lines of one rotary encoder, which are already synchronous to clk. Decodes each legal Gray-code transition into an up or down quarter-step. Accumulates quarter-steps into a WIDTH-bit value that feeds the downstream PWM channel. One instance per colour channel, placed directly after the two debounce instances for that encoder's A and B pins.

Parameters:
- WIDTH, 8, width of value output.
- STEP, 1, amount added to or subtracted from value per counted step; must be less than 2**WIDTH.
- PULSES_PER_STEP, 4, number of legal quarter-steps per counted step; legal values are 1, 2 and 4 (4 means one count per detent).
- SATURATE, 0, 0 means value wraps modulo 2**WIDTH; 1 means value clamps at 0 and at 2**WIDTH-1.
- RESET_VALUE, 0, value loaded on reset.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- enc_a  input  1  debounced encoder phase A.
- enc_b  input  1  debounced encoder phase B.
- value  output  WIDTH  current count, registered.
- step_pulse  output  1  one-cycle pulse, high on the cycle value changes.
- dir  output  1  direction of the most recent counted step; 1 = up, 0 = down.
- err  output  1  one-cycle pulse on an illegal transition (both phases changed together).

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - value <= RESET_VALUE; step_pulse, dir, err <= 0; acc <= 0.
  - prev_ab <= {enc_a,enc_b}, so releasing reset mid-rotation never produces a spurious count.
- Every non-reset cycle, cur_ab = {enc_a,enc_b} is classified against prev_ab, then prev_ab <= cur_ab.
  - UP: 00->01, 01->11, 11->10, 10->00.
  - DOWN: 00->10, 10->11, 11->01, 01->00.
  - NONE: cur_ab == prev_ab.
  - ILLEGAL: 00<->11, 01<->10. err <= 1 for one cycle; acc and value unchanged.
- Quarter-step accumulator acc is signed and holds the range -(PPS-1)..+(PPS-1), where PPS = PULSES_PER_STEP. It is sized to hold that range.
  - UP: if acc == PPS-1, then acc <= 0 and a step-up is issued; otherwise acc <= acc+1.
  - DOWN: if acc == -(PPS-1), then acc <= 0 and a step-down is issued; otherwise acc <= acc-1.
  - A reversal mid-detent walks acc back toward 0; no step is issued.
  - With PPS=1, every legal transition issues a step.
- Step-up:
  - dir <= 1.
  - SATURATE=0: value <= (value+STEP) mod 2**WIDTH.
  - SATURATE=1: if value+STEP > 2**WIDTH-1, then value <= 2**WIDTH-1; otherwise value <= value+STEP. Compute the sum at WIDTH+1 bits.
- Step-down: mirror image. dir <= 0; wrap mod 2**WIDTH, or clamp at 0 when value < STEP.
- step_pulse <= 1 only if the new value differs from the old value. At a saturation limit, dir still updates but step_pulse stays 0.
- Latency: an input edge sampled at clk edge N shows on value, step_pulse and err after edge N+1 (one registered stage past the prev_ab compare).
- step_pulse and err are never high in the same cycle. Both are 0 on NONE cycles.
- Reset asserted mid-detent discards acc; no partial step survives reset.

Decomposition:
- Shared include file quad_defs.vh holds:
  - localparam transition codes TR_NONE=2'd0, TR_UP=2'd1, TR_DOWN=2'd2, TR_ILLEGAL=2'd3.
  - The legal ab sequence constants.
- One combinational sub-module, quad_step_decode:
  - Inputs: prev_ab[1:0], cur_ab[1:0].
  - Output: tr[1:0].
  - Implemented as a 16-entry case and reusable by any later encoder or jog block.
- quad_encoder_counter holds prev_ab, acc, the value arithmetic and the output registers. Target size is about 150 lines.

Test Plan:
- Reset and release with enc_a=1, enc_b=1: value=0, step_pulse=0, err=0 for 10 idle cycles. No spurious count from prev_ab.
- PPS=4, STEP=1, one full UP detent 00->01->11->10->00 with 3 cycles per state: exactly one step_pulse, on the cycle after the final 00 is sampled; value=1, dir=1.
- PPS=4, three UP quarter-steps, then three DOWN quarter-steps back to 00: no step_pulse, value unchanged, acc returns to 0.
- SATURATE=0, RESET_VALUE=255, one UP detent: value=0, step_pulse=1. SATURATE=1, same stimulus: value stays 255, step_pulse=0, dir=1.
- Illegal jump 00->11: err high for exactly one cycle, value unchanged. A following 11->10 counts as a normal UP quarter-step.
- PPS=1, STEP=5, value=3, one DOWN transition with SATURATE=1: value=0, step_pulse=1, dir=0. Repeat the same transition: value stays 0, step_pulse=0.
